gppcu_lmem_dma: RTL
===================

// Module: gppcu_lmem_dma
// PURPOSE
//  Initiator side of the thread local-memory (LMEM) port. Moves word bursts between
//  host-side valid/ready streams and the LMEM of one selected compute thread (or all
//  threads, broadcast write). Sits between the host bridge and the thread array; its
//  LMEM outputs drive each thread's LMEM select/write-enable/address/write-data inputs.
// PARAMETERS
//  DBW      32  data word width
//  ABW      10  LMEM word-address width
//  NTHREAD   8  number of threads
//  TSW       3  thread-index width, clog2(NTHREAD)
// PORTS
//  iACLK        in   1            clock; the LMEM clock is tied to iACLK
//  iARESETn     in   1            async reset, active low
//  iCMD_VALID   in   1            command valid
//  oCMD_READY   out  1            command accepted when VALID&READY
//  iCMD_DIR     in   1            0 = host->LMEM write, 1 = LMEM->host read
//  iCMD_BCAST   in   1            write to all threads (ignored when DIR=1)
//  iCMD_THREAD  in   TSW          target thread index
//  iCMD_ADDR    in   ABW          start word address
//  iCMD_LEN     in   ABW+1        burst length in words, 0..2^ABW
//  iWDATA_VALID in   1            write-stream valid
//  oWDATA_READY out  1            write-stream ready
//  iWDATA       in   DBW          write-stream data
//  oRDATA_VALID out  1            read-stream valid
//  iRDATA_READY in   1            read-stream ready
//  oRDATA       out  DBW          read-stream data
//  oLMEMSEL     out  NTHREAD      one-hot thread select (all ones on broadcast write)
//  oLMEMWREN    out  1            LMEM write enable
//  oLMEMADDR    out  ABW          LMEM word address
//  oLMEMWDATA   out  DBW          LMEM write data
//  iLMEMRDATA   in   NTHREAD*DBW  packed thread read data, thread k at [k*DBW +: DBW]
//  oBUSY        out  1            high in any state other than IDLE
//  oDONE        out  1            one-cycle pulse at end of every accepted command
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; all outputs 0 except
//    oCMD_READY=1; read FIFO emptied, in-flight read dropped.
//  - Reset mid-burst: oLMEMWREN and oLMEMSEL drop immediately; no oDONE; burst lost.
//  - States: IDLE, WRITE, READ, DRAIN, DONE. oCMD_READY=1 only in IDLE.
//  - IDLE: on accepted command, latch fields. LEN=0 -> DONE; DIR=0 -> WRITE;
//    DIR=1 -> READ.
//  - WRITE: oWDATA_READY=1 while words remain. Each beat accepted in cycle t gives,
//    registered, oLMEMWREN=1, oLMEMADDR=current address, oLMEMWDATA=iWDATA and
//    oLMEMSEL set, in cycle t+1. No beat in cycle t -> oLMEMWREN=0 in t+1.
//    After the last beat: WRITE -> DONE, with the last write presented in that cycle.
//  - READ: LMEM read is synchronous, 1-cycle latency. A read is issued with oLMEMWREN=0
//    and oLMEMSEL/oLMEMADDR set; data is captured from slice iCMD_THREAD of
//    iLMEMRDATA one cycle later into a 2-entry FIFO.
//    Issue rule: issue only if FIFO occupancy + in-flight reads < 2.
//    oRDATA/oRDATA_VALID come from the FIFO head. After the last issue: READ -> DRAIN.
//  - DRAIN: wait until nothing is in flight and the FIFO is empty, then -> DONE.
//  - DONE: oDONE=1 for one cycle, then -> IDLE.
//  - Address increments by 1 per word, modulo 2^ABW: 0x3FF wraps to 0x000.
//    The remaining count is ABW+1 bits; LEN=2^ABW is legal.
//  - oLMEMSEL is 0 whenever no LMEM access is presented, so idle threads are not
//    selected.
//  - iCMD_THREAD >= NTHREAD: no thread selected; writes are discarded; reads return 0;
//    the handshake and oDONE behave normally.
// TESTING
//  - Write: thread 2, addr 0x010, LEN 4, data A0..A3 streamed with no gaps ->
//    oLMEMSEL=0x04 for 4 consecutive cycles at 0x010..0x013; oDONE 1 cycle after the
//    last write.
//  - Broadcast write: BCAST=1, LEN 2, addr 0x3FF -> oLMEMSEL=0xFF; addresses 0x3FF
//    then 0x000 (wrap).
//  - Read: thread 5, addr 0x020, LEN 8, memory model returns addr^0x55,
//    iRDATA_READY=1 -> 8 beats in order, sustained 1 word per cycle after 2-cycle
//    latency.
//  - Read backpressure: LEN 8, iRDATA_READY toggling 1010... -> no lost or duplicated
//    words; at most 2 words buffered.
//  - LEN=0 -> oDONE pulses 2 cycles after acceptance; no oLMEMSEL activity.
//  - iARESETn low during word 3 of a LEN 8 write -> oLMEMWREN=0 and oLMEMSEL=0
//    asynchronously; after release, oCMD_READY=1 and a new command completes normally.

Source files
------------

// File: rtl/gppcu_lmem_dma_if.sv
`default_nettype none
// ============================================================================
// Module   : gppcu_lmem_dma_if
// Purpose  : Bundles the command, write-stream, read-stream and thread-LMEM
//            signals of the LMEM DMA initiator.
// Ports    : none (signal bundle only)
//            master modport : DMA side (drives o* signals)
//            slave  modport : host bridge / thread array side (drives i*)
// Revision : 1.0 - initial release
// ============================================================================
interface gppcu_lmem_dma_if #(
  parameter int DBW     = 32,
  parameter int ABW     = 10,
  parameter int NTHREAD = 8,
  parameter int TSW     = 3
);
  logic                   iCMD_VALID;
  logic                   oCMD_READY;
  logic                   iCMD_DIR;
  logic                   iCMD_BCAST;
  logic [TSW-1:0]         iCMD_THREAD;
  logic [ABW-1:0]         iCMD_ADDR;
  logic [ABW:0]           iCMD_LEN;
  logic                   iWDATA_VALID;
  logic                   oWDATA_READY;
  logic [DBW-1:0]         iWDATA;
  logic                   oRDATA_VALID;
  logic                   iRDATA_READY;
  logic [DBW-1:0]         oRDATA;
  logic [NTHREAD-1:0]     oLMEMSEL;
  logic                   oLMEMWREN;
  logic [ABW-1:0]         oLMEMADDR;
  logic [DBW-1:0]         oLMEMWDATA;
  logic [NTHREAD*DBW-1:0] iLMEMRDATA;
  logic                   oBUSY;
  logic                   oDONE;

  modport master (
    input  iCMD_VALID, iCMD_DIR, iCMD_BCAST, iCMD_THREAD, iCMD_ADDR, iCMD_LEN,
           iWDATA_VALID, iWDATA, iRDATA_READY, iLMEMRDATA,
    output oCMD_READY, oWDATA_READY, oRDATA_VALID, oRDATA, oLMEMSEL,
           oLMEMWREN, oLMEMADDR, oLMEMWDATA, oBUSY, oDONE
  );

  modport slave (
    output iCMD_VALID, iCMD_DIR, iCMD_BCAST, iCMD_THREAD, iCMD_ADDR, iCMD_LEN,
           iWDATA_VALID, iWDATA, iRDATA_READY, iLMEMRDATA,
    input  oCMD_READY, oWDATA_READY, oRDATA_VALID, oRDATA, oLMEMSEL,
           oLMEMWREN, oLMEMADDR, oLMEMWDATA, oBUSY, oDONE
  );
endinterface
`default_nettype wire

// File: rtl/gppcu_lmem_dma.sv
`default_nettype none
// ============================================================================
// Module   : gppcu_lmem_dma
// Purpose  : Initiator side of the thread local-memory port. Moves word bursts
//            between host valid/ready streams and the LMEM of one thread (or
//            all threads for a broadcast write).
// Ports    : iACLK    - clock (LMEM shares this clock)
//            iARESETn - asynchronous active-low reset
//            bus      - command / write stream / read stream / LMEM signals
// Revision : 1.0 - initial release
// ============================================================================
module gppcu_lmem_dma #(
  parameter int DBW     = 32,
  parameter int ABW     = 10,
  parameter int NTHREAD = 8,
  parameter int TSW     = 3
) (
  input  logic                 iACLK,
  input  logic                 iARESETn,
  gppcu_lmem_dma_if.master     bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               bcast_q;
  logic [TSW-1:0]     thread_q;
  logic [ABW-1:0]     addr_q;
  logic [ABW:0]       rem_q;
  logic               wren_q;
  logic [NTHREAD-1:0] wsel_q;
  logic [ABW-1:0]     waddr_q;
  logic [DBW-1:0]     wdata_q;
  logic               ret_q;     // read data is on iLMEMRDATA this cycle
  logic [DBW-1:0]     fifo_q [2];
  logic               fifo_wp_q, fifo_rp_q;
  logic [1:0]         fifo_cnt_q;
  logic               done_q;

  logic               w_cmd_fire, w_thr_ok, w_wready, w_wbeat;
  logic               w_rvalid, w_pop, w_rd_issue;
  logic [1:0]         w_occ;
  logic [NTHREAD-1:0] w_sel_thr, w_sel_wr;
  logic [DBW-1:0]     w_rd_word;

  assign w_cmd_fire = bus.iCMD_VALID && (state_q == S_IDLE);
  assign w_thr_ok   = ({1'b0, thread_q} < (TSW+1)'(NTHREAD));
  assign w_sel_thr  = w_thr_ok ? (NTHREAD'(1) << thread_q) : '0;
  assign w_sel_wr   = bcast_q ? '1 : w_sel_thr;
  assign w_wready   = (state_q == S_WRITE) && (rem_q != '0);
  assign w_wbeat    = w_wready && bus.iWDATA_VALID;
  assign w_rvalid   = (fifo_cnt_q != 2'd0);
  assign w_pop      = w_rvalid && bus.iRDATA_READY;

  // Occupancy the FIFO will have once this cycle's pop and the returning
  // word are accounted for. Reads are presented combinationally so a read
  // issued now lands one cycle after the word currently returning; crediting
  // the pop is what lets a 2-entry FIFO sustain one word per cycle.
  assign w_occ      = fifo_cnt_q - {1'b0, w_pop} + {1'b0, ret_q};
  assign w_rd_issue = (state_q == S_READ) && (rem_q != '0) && (w_occ < 2'd2);

  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < NTHREAD; k++) begin
      if (w_thr_ok && (thread_q == TSW'(k))) begin
        w_rd_word = bus.iLMEMRDATA[k*DBW +: DBW];
      end
    end
  end

  // State register
  always_ff @(posedge iACLK or negedge iARESETn) begin
    if (!iARESETn) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_cmd_fire) begin
          if (bus.iCMD_LEN == '0) state_d = S_DONE;
          else if (bus.iCMD_DIR)  state_d = S_READ;
          else                    state_d = S_WRITE;
        end
      end
      S_WRITE: if (w_wbeat && (rem_q == (ABW+1)'(1)))    state_d = S_DONE;
      S_READ:  if (w_rd_issue && (rem_q == (ABW+1)'(1))) state_d = S_DRAIN;
      S_DRAIN: if (!ret_q && (fifo_cnt_q == 2'd0))       state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: command fields, address/count, write pipeline, read FIFO
  always_ff @(posedge iACLK or negedge iARESETn) begin
    if (!iARESETn) begin
      bcast_q    <= 1'b0;
      thread_q   <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      wren_q     <= 1'b0;
      wsel_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      ret_q      <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        bcast_q  <= bus.iCMD_BCAST && !bus.iCMD_DIR;
        thread_q <= bus.iCMD_THREAD;
        addr_q   <= bus.iCMD_ADDR;
        rem_q    <= bus.iCMD_LEN;
      end else if (w_wbeat || w_rd_issue) begin
        addr_q <= addr_q + 1'b1;   // wraps modulo 2^ABW
        rem_q  <= rem_q - 1'b1;
      end
      wren_q <= w_wbeat;
      wsel_q <= w_wbeat ? w_sel_wr : '0;
      if (w_wbeat) begin
        waddr_q <= addr_q;
        wdata_q <= bus.iWDATA;
      end
      ret_q <= w_rd_issue;
      if (ret_q) begin
        fifo_q[fifo_wp_q] <= w_rd_word;
        fifo_wp_q         <= ~fifo_wp_q;
      end
      if (w_pop) fifo_rp_q <= ~fifo_rp_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, ret_q} - {1'b0, w_pop};
      done_q     <= (state_q == S_DONE);
    end
  end

  assign bus.oCMD_READY   = (state_q == S_IDLE);
  assign bus.oWDATA_READY = w_wready;
  assign bus.oRDATA_VALID = w_rvalid;
  assign bus.oRDATA       = fifo_q[fifo_rp_q];
  assign bus.oLMEMSEL     = wsel_q | (w_rd_issue ? w_sel_thr : '0);
  assign bus.oLMEMWREN    = wren_q;
  assign bus.oLMEMADDR    = w_rd_issue ? addr_q : waddr_q;
  assign bus.oLMEMWDATA   = wdata_q;
  assign bus.oBUSY        = (state_q != S_IDLE);
  assign bus.oDONE        = done_q;

endmodule
`default_nettype wire
